ibex_load_store_unit_lite: RTL
==============================

IBEX_LOAD_STORE_UNIT_LITE -- requirements
Module: ibex_load_store_unit_lite

Interface
REQ-001 SHALL have parameter: MisalignedEn, 1'b1, 1 = split misaligned accesses into two bus transactions; 0 = flag them as errors with no bus access.
REQ-002 SHALL use one clock and a synchronous, active-high reset; ports clk_i (in, 1, clock) and rst_i (in, 1, synchronous active-high reset).
REQ-003 SHALL have ID/EX request ports:
- lsu_req_i (in, 1): request.
- lsu_we_i (in, 1): store.
- lsu_type_i (in, 2): 00 word, 01 half, 10 byte.
- lsu_sign_ext_i (in, 1): sign-extend load data.
- lsu_addr_i (in, 32).
- lsu_wdata_i (in, 32).
- lsu_req_done_o (out, 1): last part granted.
REQ-004 SHALL have data bus ports:
- data_req_o (out, 1), data_gnt_i (in, 1), data_rvalid_i (in, 1), data_err_i (in, 1).
- data_addr_o (out, 32), data_we_o (out, 1), data_be_o (out, 4).
- data_wdata_o (out, 32), data_rdata_i (in, 32).
REQ-005 SHALL have writeback-side ports:
- lsu_rdata_o (out, 32): RF load data.
- lsu_rdata_valid_o (out, 1): RF write enable.
- lsu_resp_valid_o (out, 1): transaction complete.
- lsu_resp_err_o (out, 1): bus or misaligned error.
- busy_o (out, 1): FSM not IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT_GNT_MIS, WAIT_RVALID_MIS, WAIT_GNT, WAIT_RVALID, with at most one bus transaction outstanding.
REQ-007 SHALL sample lsu_req_i only in IDLE; the issuer holds all request inputs stable until lsu_req_done_o.
REQ-008 SHALL drive data_req_o combinationally in IDLE when lsu_req_i=1 (zero latency), and hold it high with stable addr/be/wdata/we in every WAIT_GNT* state until data_gnt_i.
REQ-009 SHALL treat an access as misaligned when it is a word with addr[1:0]!=0, or a half with addr[1:0]==3.
REQ-010 SHALL issue the first part at {addr[31:2],2'b00} and the second part at that address +4, wrapping modulo 2^32.
REQ-011 SHALL generate byte enables, with off=addr[1:0]:
- word: first part 4'b1111<<off, second part 4'b1111>>(4-off).
- half: 4'b0011<<off (first part 4'b1000 and second part 4'b0001 when off=3).
- byte: 4'b0001<<off.
REQ-012 SHALL set data_wdata_o to lsu_wdata_i rotated left by 8*off bits, identical for both parts.
REQ-013 SHALL apply these transitions:
- IDLE: aligned -> WAIT_RVALID on gnt, else WAIT_GNT; misaligned -> WAIT_RVALID_MIS on gnt, else WAIT_GNT_MIS.
- WAIT_GNT_MIS: gnt -> WAIT_RVALID_MIS.
- WAIT_RVALID_MIS: rvalid -> WAIT_GNT (second part).
- WAIT_GNT: gnt -> WAIT_RVALID.
- WAIT_RVALID: rvalid -> IDLE.
REQ-014 SHALL accept a new request at the earliest in the cycle after the final rvalid (IDLE).
REQ-015 SHALL pulse lsu_req_done_o for one cycle with the data_gnt_i of the final part.
REQ-016 SHALL latch data_rdata_i and data_err_i on first-part rvalid; the final load data merges the latched upper bytes (>>8*off) with the second-part low bytes, then zero- or sign-extends from bit 7/15 per lsu_type_i and lsu_sign_ext_i.
REQ-017 SHALL issue the second part even if the first part errored; lsu_resp_err_o = OR of both parts' errors.
REQ-018 SHALL assert lsu_resp_valid_o for one cycle on the final rvalid; lsu_rdata_valid_o = lsu_resp_valid_o & ~lsu_we_q & ~lsu_resp_err_o.
REQ-019 SHALL ignore data_rvalid_i in IDLE and WAIT_GNT* states.
REQ-020 SHALL handle misaligned requests when MisalignedEn=0 as follows: no data_req_o; lsu_req_done_o and lsu_resp_valid_o with lsu_resp_err_o in the same cycle; remain in IDLE.

Reset
REQ-021 SHALL, while rst_i=1 at a clock edge, set the FSM to IDLE and clear latched rdata/err/type/offset/we to 0.
REQ-022 SHALL force data_req_o, lsu_req_done_o, lsu_resp_valid_o, lsu_rdata_valid_o and lsu_resp_err_o to 0 while rst_i=1, including mid-transaction; a bus response arriving after reset is ignored.

Structure
REQ-023 SHALL place the lsu_type_e enum (word/half/byte) and the FSM state enum in ibex_pkg.
REQ-024 SHALL use one sub-module, ibex_lsu_rdata_align, as combinational merge/extend logic.

Verification
REQ-025 SHALL cover an aligned word load at addr 0x100 with gnt same cycle and rvalid +2 returning 0xDEADBEEF -> lsu_rdata_o=0xDEADBEEF with lsu_rdata_valid_o for 1 cycle, data_be_o=4'hF.
REQ-026 SHALL cover a misaligned word load at 0x103 with parts returning 0x11223344 and 0x55667788 -> bus addrs 0x100 then 0x104, be 4'h8 then 4'h7, result 0x66778811.
REQ-027 SHALL cover a signed byte load at 0x202 of data 0x00800000 -> lsu_rdata_o=0xFFFFFF80; unsigned -> 0x00000080.
REQ-028 SHALL cover a half store of 0x0000ABCD at 0x1 with gnt delayed 3 cycles -> data_req_o held 4 cycles, be 4'h6, wdata 0x00ABCD00, lsu_rdata_valid_o=0.
REQ-029 SHALL cover a misaligned half load at 0xFFFFFFFF with a first-part data_err_i=1 -> second part issued at 0x00000000, lsu_resp_err_o=1, lsu_rdata_valid_o=0.
REQ-030 SHALL cover rst_i asserted in WAIT_RVALID with a late rvalid after reset -> busy_o=0, no lsu_resp_valid_o.

Source files
------------

// File: rtl/ibex_pkg.sv
// Shared types and helpers for the lightweight Ibex load/store unit.
// Holds the access-size and FSM-state enums plus byte-enable and write-data alignment helpers.
package ibex_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_type_e;

  typedef enum logic [2:0] {
    LSU_IDLE            = 3'd0,
    LSU_WAIT_GNT_MIS    = 3'd1,
    LSU_WAIT_RVALID_MIS = 3'd2,
    LSU_WAIT_GNT        = 3'd3,
    LSU_WAIT_RVALID     = 3'd4
  } lsu_state_e;

  // The unused type encoding 2'b11 is handled as a word everywhere in the unit.
  function automatic logic lsu_is_misaligned(input lsu_type_e typ, input logic [1:0] off);
    logic mis;
    case (typ)
      LSU_HALF: mis = (off == 2'b11);
      LSU_BYTE: mis = 1'b0;
      default:  mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] lsu_be(input lsu_type_e typ, input logic [1:0] off,
                                        input logic second);
    logic [3:0] be;
    case (typ)
      LSU_HALF: begin
        if (off == 2'b11) be = second ? 4'b0001 : 4'b1000;
        else              be = 4'b0011 << off;
      end
      LSU_BYTE: be = 4'b0001 << off;
      default:  be = second ? (4'b1111 >> (3'd4 - {1'b0, off})) : (4'b1111 << off);
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lsu_wdata_rotate(input logic [31:0] wdata, input logic [1:0] off);
    logic [31:0] rot;
    case (off)
      2'd1:    rot = {wdata[23:0], wdata[31:24]};
      2'd2:    rot = {wdata[15:0], wdata[31:16]};
      2'd3:    rot = {wdata[7:0],  wdata[31:8]};
      default: rot = wdata;
    endcase
    return rot;
  endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Combinational load-data path: merges the two halves of a split access,
// shifts the addressed bytes down to bit 0 and zero- or sign-extends them.
module ibex_lsu_rdata_align
  import ibex_pkg::*;
(
  input  logic [31:0] i_rdata_first,
  input  logic [31:0] i_rdata_second,
  input  logic [1:0]  i_off,
  input  logic        i_split,
  input  lsu_type_e   i_type,
  input  logic        i_sign_ext,
  output logic [31:0] o_rdata
);

  logic [31:0] w_merged;
  logic [31:0] w_shifted;
  logic [31:0] w_data;

  // A split access keeps the upper bytes of the first word as the low result bytes.
  always_comb begin
    case (i_off)
      2'd1:    w_merged = {i_rdata_second[7:0],  i_rdata_first[31:8]};
      2'd2:    w_merged = {i_rdata_second[15:0], i_rdata_first[31:16]};
      2'd3:    w_merged = {i_rdata_second[23:0], i_rdata_first[31:24]};
      default: w_merged = i_rdata_second;
    endcase
  end

  assign w_shifted = i_rdata_second >> {i_off, 3'b000};
  assign w_data    = i_split ? w_merged : w_shifted;

  always_comb begin
    case (i_type)
      LSU_HALF: o_rdata = {{16{i_sign_ext & w_data[15]}}, w_data[15:0]};
      LSU_BYTE: o_rdata = {{24{i_sign_ext & w_data[7]}},  w_data[7:0]};
      default:  o_rdata = w_data;
    endcase
  end

endmodule

// File: rtl/ibex_load_store_unit_lite.sv
// Lightweight load/store unit: one outstanding data-bus transaction, with misaligned
// accesses either split into two word-aligned parts or rejected as errors.
module ibex_load_store_unit_lite
  import ibex_pkg::*;
#(
  parameter bit MisalignedEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_req_done_o,

  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,

  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rdata_valid_o,
  output logic        lsu_resp_valid_o,
  output logic        lsu_resp_err_o,
  output logic        busy_o
);

  lsu_state_e  r_state;
  logic [31:0] r_rdata_q;
  logic        r_err_q;
  lsu_type_e   r_type_q;
  logic [1:0]  r_off_q;
  logic        r_we_q;
  logic        r_sign_q;
  logic        r_split_q;

  lsu_type_e   w_type_in;
  logic [1:0]  w_off_in;
  logic        w_mis_in;
  logic        w_mis_err;
  logic        w_idle;
  logic        w_second;
  lsu_type_e   w_type;
  logic [1:0]  w_off;
  logic [31:0] w_word_addr;

  assign w_type_in = lsu_type_e'(lsu_type_i);
  assign w_off_in  = lsu_addr_i[1:0];
  assign w_mis_in  = lsu_is_misaligned(w_type_in, w_off_in);
  assign w_mis_err = lsu_req_i & w_mis_in & ~MisalignedEn;
  assign w_idle    = (r_state == LSU_IDLE);
  assign w_second  = (r_state == LSU_WAIT_GNT) & r_split_q;

  // Once a request is accepted, size and offset come from the latched copy.
  assign w_type      = w_idle ? w_type_in : r_type_q;
  assign w_off       = w_idle ? w_off_in  : r_off_q;
  assign w_word_addr = {lsu_addr_i[31:2], 2'b00};

  assign data_addr_o  = w_second ? (w_word_addr + 32'd4) : w_word_addr;
  assign data_be_o    = lsu_be(w_type, w_off, w_second);
  assign data_wdata_o = lsu_wdata_rotate(lsu_wdata_i, w_off);
  assign data_we_o    = lsu_we_i;
  assign busy_o       = ~w_idle;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= LSU_IDLE;
      r_rdata_q <= 32'd0;
      r_err_q   <= 1'b0;
      r_type_q  <= LSU_WORD;
      r_off_q   <= 2'd0;
      r_we_q    <= 1'b0;
      r_sign_q  <= 1'b0;
      r_split_q <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (lsu_req_i) begin
            r_type_q  <= w_type_in;
            r_off_q   <= w_off_in;
            r_we_q    <= lsu_we_i;
            r_sign_q  <= lsu_sign_ext_i;
            r_split_q <= w_mis_in;
            r_err_q   <= 1'b0;
            if (!w_mis_err) begin
              if (w_mis_in) r_state <= data_gnt_i ? LSU_WAIT_RVALID_MIS : LSU_WAIT_GNT_MIS;
              else          r_state <= data_gnt_i ? LSU_WAIT_RVALID     : LSU_WAIT_GNT;
            end
          end
        end
        LSU_WAIT_GNT_MIS: begin
          if (data_gnt_i) r_state <= LSU_WAIT_RVALID_MIS;
        end
        LSU_WAIT_RVALID_MIS: begin
          if (data_rvalid_i) begin
            r_rdata_q <= data_rdata_i;
            r_err_q   <= data_err_i;
            r_state   <= LSU_WAIT_GNT;
          end
        end
        LSU_WAIT_GNT: begin
          if (data_gnt_i) r_state <= LSU_WAIT_RVALID;
        end
        LSU_WAIT_RVALID: begin
          if (data_rvalid_i) r_state <= LSU_IDLE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  // Handshake outputs are combinational and all forced low during reset.
  always_comb begin
    data_req_o       = 1'b0;
    lsu_req_done_o   = 1'b0;
    lsu_resp_valid_o = 1'b0;
    lsu_resp_err_o   = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        data_req_o       = lsu_req_i & ~w_mis_err;
        lsu_req_done_o   = w_mis_err | (lsu_req_i & data_gnt_i & ~w_mis_in);
        lsu_resp_valid_o = w_mis_err;
        lsu_resp_err_o   = w_mis_err;
      end
      LSU_WAIT_GNT_MIS: begin
        data_req_o = 1'b1;
      end
      LSU_WAIT_GNT: begin
        data_req_o     = 1'b1;
        lsu_req_done_o = data_gnt_i;
      end
      LSU_WAIT_RVALID: begin
        lsu_resp_valid_o = data_rvalid_i;
        lsu_resp_err_o   = data_rvalid_i & (r_err_q | data_err_i);
      end
      default: ;
    endcase
    if (rst_i) begin
      data_req_o       = 1'b0;
      lsu_req_done_o   = 1'b0;
      lsu_resp_valid_o = 1'b0;
      lsu_resp_err_o   = 1'b0;
    end
  end

  assign lsu_rdata_valid_o = lsu_resp_valid_o & ~r_we_q & ~lsu_resp_err_o;

  ibex_lsu_rdata_align u_rdata_align (
    .i_rdata_first  (r_rdata_q),
    .i_rdata_second (data_rdata_i),
    .i_off          (r_off_q),
    .i_split        (r_split_q),
    .i_type         (r_type_q),
    .i_sign_ext     (r_sign_q),
    .o_rdata        (lsu_rdata_o)
  );

endmodule
